lemmings_dig_arbiter: RTL and testbench

Shares a single digging tool among N_LEM walker FSMs. Each walker may request the tool only while it is on ground. The block grants the tool round-robin, holds it for a fixed dig duration, and ends every grant with exactly one of three outcomes: completion, abort on ground loss, or early release. A cooldown follows every grant. It sits between the per-lemming walker FSMs and the shared terrain-modify datapath.

---
 rtl/lemmings_pkg.sv | 16 +
 rtl/lemmings_rr_pick.sv | 50 +++++
 rtl/lemmings_dig_arbiter.sv | 156 +++++++++++++++
 tb/tb_lemmings_dig_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lemmings_pkg.sv
// Shared types for the lemmings walker FSMs and the dig-tool arbiter.
// Both sides import this so state encodings and direction codes stay in sync.
package lemmings_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG  = 2'd1,
    COOL = 2'd2
  } arb_state_t;

  typedef enum logic {
    WL = 1'b0,
    WR = 1'b1
  } walker_dir_t;

endpackage

// File: rtl/lemmings_rr_pick.sv
// Combinational round-robin picker: first set bit of i_mask scanning from
// i_ptr upward with wrap. Reusable for any shared-resource arbiter.
module lemmings_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [2*N-1:0]       w_dbl;
  logic [N-1:0]         w_rot;
  logic [N-1:0]         w_first;
  logic [N:0]           w_seen;
  logic [N:0][IW-1:0]   w_off_acc;
  logic [IW:0]          w_sum;
  logic [IW-1:0]        w_idx;

  // Rotating the doubled mask puts the bit at i_ptr into position 0.
  assign w_dbl = {i_mask, i_mask};
  assign w_rot = N'(w_dbl >> i_ptr);

  assign w_seen[0]    = 1'b0;
  assign w_off_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_scan
      assign w_first[gi]      = w_rot[gi] & ~w_seen[gi];
      assign w_seen[gi+1]     = w_seen[gi] | w_rot[gi];
      assign w_off_acc[gi+1]  = w_off_acc[gi] | (w_first[gi] ? IW'(gi) : '0);
    end
  endgenerate

  // Offset is relative to i_ptr; fold back into 0..N-1 without a divider.
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off_acc[N]};
  assign w_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];

  assign o_valid = |i_mask;
  assign o_idx   = o_valid ? w_idx : '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_pick[gi] = o_valid & (w_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/lemmings_dig_arbiter.sv
// Round-robin owner of the shared digging tool: grant, fixed-length dig,
// one terminal outcome (done / abort / early release), then cooldown.
module lemmings_dig_arbiter
  import lemmings_pkg::*;
#(
  parameter  int N_LEM       = 4,
  parameter  int DIG_CYCLES  = 8,
  parameter  int COOL_CYCLES = 2,
  localparam int IW          = $clog2(N_LEM),
  localparam int CW          = $clog2(DIG_CYCLES + COOL_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [N_LEM-1:0] dig_req,
  input  logic [N_LEM-1:0] ground,
  output logic [N_LEM-1:0] dig_grant,
  output logic [IW-1:0]    owner_idx,
  output logic             owner_valid,
  output logic [N_LEM-1:0] dig_done,
  output logic [N_LEM-1:0] dig_abort,
  output logic             busy
);

  localparam logic [CW-1:0] DIG_LAST  = CW'(DIG_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);

  arb_state_t       r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [IW-1:0]    r_ptr, w_ptr_next;
  logic [N_LEM-1:0] r_grant, w_grant_next;
  logic [IW-1:0]    r_owner, w_owner_next;
  logic             r_valid, w_valid_next;
  logic [N_LEM-1:0] r_done, w_done_next;
  logic [N_LEM-1:0] r_abort, w_abort_next;
  logic             r_busy, w_busy_next;

  logic [N_LEM-1:0] w_elig;
  logic [N_LEM-1:0] w_pick;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_valid;
  logic             w_own_ground;
  logic             w_own_req;
  logic             w_release;

  assign w_elig = dig_req & ground;

  lemmings_rr_pick #(
    .N (N_LEM)
  ) u_pick (
    .i_mask  (w_elig),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // r_grant is one-hot while digging, so masking selects the owner's bits.
  assign w_own_ground = |(ground & r_grant);
  assign w_own_req    = |(dig_req & r_grant);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_owner <= '0;
      r_valid <= 1'b0;
      r_done  <= '0;
      r_abort <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_abort <= w_abort_next;
      r_busy  <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_done_next  = '0;
    w_abort_next = '0;
    w_release    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next = DIG;
          w_cnt_next   = '0;
          w_grant_next = w_pick;
          w_owner_next = w_pick_idx;
          w_ptr_next   = (w_pick_idx == IW'(N_LEM - 1)) ? '0 : w_pick_idx + IW'(1);
        end
      end

      DIG: begin
        // Ground loss outranks everything, including the final dig cycle.
        if (!w_own_ground) begin
          w_abort_next = r_grant;
          w_release    = 1'b1;
        end else if (!w_own_req) begin
          w_release    = 1'b1;
        end else if (r_cnt == DIG_LAST) begin
          w_done_next  = r_grant;
          w_release    = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CW'(1);
        end
      end

      COOL: begin
        if (r_cnt == COOL_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_grant_next = '0;
        w_owner_next = '0;
      end
    endcase

    if (w_release) begin
      w_grant_next = '0;
      w_owner_next = '0;
      w_cnt_next   = '0;
      w_state_next = (COOL_CYCLES == 0) ? IDLE : COOL;
    end

    w_valid_next = |w_grant_next;
    w_busy_next  = (w_state_next != IDLE);
  end

  assign dig_grant   = r_grant;
  assign owner_idx   = r_owner;
  assign owner_valid = r_valid;
  assign dig_done    = r_done;
  assign dig_abort   = r_abort;
  assign busy        = r_busy;

endmodule

// File: tb/tb_lemmings_dig_arbiter.sv
// Self-checking bench for lemmings_dig_arbiter (N_LEM=4, DIG=8, COOL=2):
// per-cycle vector tables feed a scoreboard queue, plus reset corner cases.
module tb_lemmings_dig_arbiter;

  logic       clk;
  logic       areset_n;
  logic [3:0] dig_req;
  logic [3:0] ground;
  logic [3:0] dig_grant;
  logic [1:0] owner_idx;
  logic       owner_valid;
  logic [3:0] dig_done;
  logic [3:0] dig_abort;
  logic       busy;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnd;
    logic [3:0] grant;
    logic [3:0] done;
    logic [3:0] abort;
    logic       busy;
  } vec_t;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur   = "init";

  lemmings_dig_arbiter #(
    .N_LEM       (4),
    .DIG_CYCLES  (8),
    .COOL_CYCLES (2)
  ) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .dig_req     (dig_req),
    .ground      (ground),
    .dig_grant   (dig_grant),
    .owner_idx   (owner_idx),
    .owner_valid (owner_valid),
    .dig_done    (dig_done),
    .dig_abort   (dig_abort),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] gnd,
                              input logic [3:0] grant, input logic [3:0] done,
                              input logic [3:0] abort, input logic bsy);
    vec_t v;
    v.req = req; v.gnd = gnd; v.grant = grant;
    v.done = done; v.abort = abort; v.busy = bsy;
    return v;
  endfunction

  task automatic cmp(input string tag, input string name,
                     input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %b want %b", tag, name, got, want);
    end
  endtask

  task automatic check(input vec_t e, input string tag);
    cmp(tag, "grant", dig_grant, e.grant);
    cmp(tag, "idx",   {2'b00, owner_idx}, {2'b00, oh2idx(e.grant)});
    cmp(tag, "valid", {3'b000, owner_valid}, {3'b000, |e.grant});
    cmp(tag, "done",  dig_done, e.done);
    cmp(tag, "abort", dig_abort, e.abort);
    cmp(tag, "busy",  {3'b000, busy}, {3'b000, e.busy});
    $display("%s: req=%b gnd=%b -> grant=%b idx=%0d done=%b abort=%b busy=%b",
             tag, dig_req, ground, dig_grant, owner_idx, dig_done, dig_abort, busy);
  endtask

  // Drive one cycle of inputs; expected outputs for the following cycle go
  // into the scoreboard and are retired just after the next rising edge.
  task automatic apply(input vec_t v, input int k);
    vec_t e;
    dig_req = v.req;
    ground  = v.gnd;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue want entry", cur);
    end else begin
      e = exp_q.pop_front();
      check(e, $sformatf("%s c%0d", cur, k + 1));
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    tbl.delete();
  endtask

  task automatic do_reset(input string name);
    cur      = name;
    areset_n = 1'b0;
    dig_req  = 4'h0;
    ground   = 4'h0;
    @(posedge clk);
    #1;
    check(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0), {name, " reset"});
    areset_n = 1'b1;
  endtask

  // Grant cadence with ground held: 8 dig cycles, done pulse, one more
  // cooldown cycle, one idle cycle, then the next grant (11-cycle period).
  task automatic add_rr(input logic [3:0] req, input int first_lem,
                        input bit rotate, input int last_cyc);
    int ph;
    int g;
    int lem;
    logic [3:0] oh;
    for (int c = 1; c <= last_cyc; c++) begin
      ph  = (c - 1) % 11;
      g   = (c - 1) / 11;
      lem = rotate ? (first_lem + g) % 4 : first_lem;
      oh  = 4'(1) << lem;
      if (ph < 8)       tbl.push_back(mk(req, 4'hF, oh,   4'h0, 4'h0, 1'b1));
      else if (ph == 8) tbl.push_back(mk(req, 4'hF, 4'h0, oh,   4'h0, 1'b1));
      else if (ph == 9) tbl.push_back(mk(req, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1));
      else              tbl.push_back(mk(req, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0));
    end
  endtask

  // Lemming 2 digs; its ground drops during cycle drop_k only.
  task automatic add_abort(input int drop_k);
    logic [3:0] g;
    for (int k = 0; k <= drop_k + 3; k++) begin
      g = (k == drop_k) ? 4'b1011 : 4'hF;
      if (k + 1 <= drop_k)       tbl.push_back(mk(4'b0100, g, 4'b0100, 4'h0, 4'h0,    1'b1));
      else if (k + 1 == drop_k + 1) tbl.push_back(mk(4'b0100, g, 4'h0, 4'h0, 4'b0100, 1'b1));
      else if (k + 1 == drop_k + 2) tbl.push_back(mk(4'b0100, g, 4'h0, 4'h0, 4'h0,    1'b1));
      else if (k + 1 == drop_k + 3) tbl.push_back(mk(4'b0100, g, 4'h0, 4'h0, 4'h0,    1'b0));
      else                          tbl.push_back(mk(4'b0100, g, 4'b0100, 4'h0, 4'h0, 1'b1));
    end
  endtask

  task automatic mid_reset();
    areset_n = 1'b0;
    #2;
    check(mk(dig_req, ground, 4'h0, 4'h0, 4'h0, 1'b0), {cur, " async_rst"});
    @(posedge clk);
    #1;
    check(mk(dig_req, ground, 4'h0, 4'h0, 4'h0, 1'b0), {cur, " rst_held"});
    areset_n = 1'b1;
  endtask

  initial begin
    areset_n = 1'b0;
    dig_req  = 4'h0;
    ground   = 4'h0;

    do_reset("t1_single");
    add_rr(4'b0010, 1, 1'b0, 12);
    run_table();

    do_reset("t2_rr");
    add_rr(4'hF, 0, 1'b1, 52);
    run_table();

    do_reset("t3a_abort");
    add_abort(3);
    run_table();

    do_reset("t3b_abort_last");
    add_abort(8);
    run_table();

    do_reset("t4_noground");
    for (int k = 0; k < 8; k++) begin
      if (k + 1 <= 5) tbl.push_back(mk(4'b0001, (k >= 5) ? 4'hF : 4'b1110, 4'h0, 4'h0, 4'h0, 1'b0));
      else            tbl.push_back(mk(4'b0001, (k >= 5) ? 4'hF : 4'b1110, 4'b0001, 4'h0, 4'h0, 1'b1));
    end
    run_table();

    do_reset("t5_release");
    for (int k = 0; k < 10; k++) begin
      if (k + 1 <= 5)      tbl.push_back(mk((k < 5) ? 4'b0001 : 4'h0, 4'hF, 4'b0001, 4'h0, 4'h0, 1'b1));
      else if (k + 1 <= 7) tbl.push_back(mk((k < 5) ? 4'b0001 : 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1));
      else                 tbl.push_back(mk((k < 5) ? 4'b0001 : 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0));
    end
    run_table();

    do_reset("t6_rst3");
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b1000, 4'hF, 4'b1000, 4'h0, 4'h0, 1'b1));
    run_table();
    mid_reset();
    cur = "t6_after";
    add_rr(4'hF, 0, 1'b1, 12);
    run_table();

    do_reset("t6b_rst1");
    for (int k = 0; k < 3; k++) tbl.push_back(mk(4'b0010, 4'hF, 4'b0010, 4'h0, 4'h0, 1'b1));
    run_table();
    mid_reset();
    cur = "t6b_after";
    add_rr(4'hF, 0, 1'b1, 3);
    run_table();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
